// File: rtl/core_inst_seq.sv
// core_inst_seq: drives core's instruction bus and reset through the nine kernel-position
// passes of one 3x3 convolution layer, then the per-pixel accumulation reads from pmem.
module core_inst_seq #(
   parameter int unsigned col       = 8,
   parameter int unsigned row       = 8,
   parameter int unsigned in_w      = 6,
   parameter int unsigned k_w       = 3,
   parameter int unsigned out_w     = 4,
   parameter int unsigned gap_cyc   = 10,
   parameter int unsigned drain_cyc = 36
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        ofifo_valid,
   output logic [33:0] inst,
   output logic        core_rst,
   output logic        busy,
   output logic        out_valid,
   output logic [3:0]  out_idx,
   output logic        done
);

   localparam int unsigned len_nij  = in_w * in_w;
   localparam int unsigned len_kij  = k_w * k_w;
   localparam int unsigned len_onij = out_w * out_w;
   localparam int unsigned crst_cyc = 11;
   localparam int unsigned acc_cyc  = len_kij + 4;
   localparam int unsigned w_base   = 1024;

   localparam logic [33:0] idle_inst = 34'h1800C0000;
   localparam int unsigned b_acc    = 33;
   localparam int unsigned b_cen_p  = 32;
   localparam int unsigned b_wen_p  = 31;
   localparam int unsigned b_a_p    = 20;
   localparam int unsigned b_cen_x  = 19;
   localparam int unsigned b_a_x    = 7;
   localparam int unsigned b_l0_rd  = 3;
   localparam int unsigned b_l0_wr  = 2;
   localparam int unsigned b_exec   = 1;
   localparam int unsigned b_load   = 0;

   if (row == 0) begin : g_bad_row
      $error("core_inst_seq: row must be non-zero");
   end

   typedef enum logic [3:0] {
      StIdle, StCrst, StWL0, StLoad, StGap, StXL0, StExec, StDrain, StOfifo, StAcc, StDone
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [3:0]  kij_q, kij_d;
   logic [3:0]  o_q, o_d, ox_q, ox_d, oy_q, oy_d, kx_q, kx_d, ky_q, ky_d;
   logic        rd_en_q, rd_en_d, rd_fire;
   logic [33:0] inst_q, inst_d;
   logic        core_rst_q, core_rst_d, busy_q, busy_d;
   logic        out_valid_q, out_valid_d, done_q, done_d;
   logic [3:0]  out_idx_q, out_idx_d;

   // ofifo_rd must never be raised against an empty OFIFO, so it is gated live by
   // ofifo_valid; the enable and every other bit come straight from flops.
   assign rd_fire   = rd_en_q & ofifo_valid;
   assign inst      = inst_q | {27'b0, rd_fire, 6'b0};
   assign core_rst  = core_rst_q;
   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign done      = done_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         kij_q       <= '0;
         o_q         <= '0;
         ox_q        <= '0;
         oy_q        <= '0;
         kx_q        <= '0;
         ky_q        <= '0;
         rd_en_q     <= 1'b0;
         inst_q      <= idle_inst;
         core_rst_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         kij_q       <= kij_d;
         o_q         <= o_d;
         ox_q        <= ox_d;
         oy_q        <= oy_d;
         kx_q        <= kx_d;
         ky_q        <= ky_d;
         rd_en_q     <= rd_en_d;
         inst_q      <= inst_d;
         core_rst_q  <= core_rst_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 8'd1;
      kij_d   = kij_q;
      o_d     = o_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      kx_d    = kx_q;
      ky_d    = ky_q;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (start) begin
               state_d = StCrst;
               kij_d   = '0;
            end
         end
         StCrst:  if (cnt_q == 8'(crst_cyc - 1)) begin state_d = StWL0;  cnt_d = '0; end
         StWL0:   if (cnt_q == 8'(col))          begin state_d = StLoad; cnt_d = '0; end
         StLoad:  if (cnt_q == 8'(col - 1))      begin state_d = StGap;  cnt_d = '0; end
         StGap:   if (cnt_q == 8'(gap_cyc - 1))  begin state_d = StXL0;  cnt_d = '0; end
         StXL0:   if (cnt_q == 8'(len_nij))      begin state_d = StExec; cnt_d = '0; end
         StExec:  if (cnt_q == 8'(len_nij - 1))  begin state_d = StDrain; cnt_d = '0; end
         StDrain: if (cnt_q == 8'(drain_cyc - 1)) begin state_d = StOfifo; cnt_d = '0; end
         StOfifo: begin
            // cnt counts reads fired; each read's pmem write goes out on the next cycle
            cnt_d = cnt_q + 8'(rd_fire);
            if (cnt_q == 8'(len_nij)) begin
               cnt_d = '0;
               if (kij_q == 4'(len_kij - 1)) begin
                  state_d = StAcc;
                  o_d     = '0;
                  ox_d    = '0;
                  oy_d    = '0;
               end else begin
                  state_d = StCrst;
                  kij_d   = kij_q + 4'd1;
               end
            end
         end
         StAcc: begin
            if (cnt_q == 8'd0) begin
               kx_d = '0;
               ky_d = '0;
            end else if (cnt_q < 8'(len_kij)) begin
               if (kx_q == 4'(k_w - 1)) begin
                  kx_d = '0;
                  ky_d = ky_q + 4'd1;
               end else begin
                  kx_d = kx_q + 4'd1;
               end
            end
            if (cnt_q == 8'(acc_cyc - 1)) begin
               cnt_d = '0;
               if (o_q == 4'(len_onij - 1)) begin
                  state_d = StDone;
               end else begin
                  o_d = o_q + 4'd1;
                  if (ox_q == 4'(out_w - 1)) begin
                     ox_d = '0;
                     oy_d = oy_q + 4'd1;
                  end else begin
                     ox_d = ox_q + 4'd1;
                  end
               end
            end
         end
         StDone: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs are decoded from the next state so the registered copy lines up with it.
   always_comb begin
      inst_d      = idle_inst;
      core_rst_d  = 1'b0;
      out_valid_d = 1'b0;
      done_d      = (state_d == StDone);
      busy_d      = (state_d != StIdle) && (state_d != StDone);
      out_idx_d   = o_d;
      rd_en_d     = (state_d == StOfifo) && (cnt_d < 8'(len_nij));
      unique case (state_d)
         StCrst: core_rst_d = 1'b1;
         StWL0: begin
            if (cnt_d < 8'(col)) begin
               inst_d[b_cen_x]       = 1'b0;
               inst_d[b_a_x +: 11]   = 11'(w_base + 32'(kij_d) * col + 32'(cnt_d));
            end
            inst_d[b_l0_wr] = (cnt_d != 8'd0);
         end
         StLoad: begin
            inst_d[b_l0_rd] = 1'b1;
            inst_d[b_load]  = 1'b1;
         end
         StXL0: begin
            if (cnt_d < 8'(len_nij)) begin
               inst_d[b_cen_x]     = 1'b0;
               inst_d[b_a_x +: 11] = 11'(cnt_d);
            end
            inst_d[b_l0_wr] = (cnt_d != 8'd0);
         end
         StExec: begin
            inst_d[b_l0_rd] = 1'b1;
            inst_d[b_exec]  = 1'b1;
         end
         StAcc: begin
            core_rst_d = (cnt_d == 8'd0);
            if ((cnt_d >= 8'd1) && (cnt_d <= 8'(len_kij))) begin
               inst_d[b_cen_p]     = 1'b0;
               inst_d[b_a_p +: 11] = 11'((32'(cnt_d) - 32'd1) * len_nij
                                         + (32'(oy_d) + 32'(ky_d)) * in_w
                                         + 32'(ox_d) + 32'(kx_d));
            end
            inst_d[b_acc] = (cnt_d >= 8'd2) && (cnt_d <= 8'(len_kij + 1));
            out_valid_d   = (cnt_d == 8'(len_kij + 3));
         end
         default: ;
      endcase
      if (rd_fire) begin
         inst_d[b_cen_p]     = 1'b0;
         inst_d[b_wen_p]     = 1'b0;
         inst_d[b_a_p +: 11] = 11'(32'(kij_q) * len_nij + 32'(cnt_q));
      end
   end

endmodule
